ahb_uart_rx: RTL and testbench
==============================

# ahb_uart_rx

AHB-Lite responder that receives 8N1 UART frames on `RXD`, buffers them in a receive FIFO, and exposes data, status and control registers to the Cortex-M0 through the AHB-Lite interconnect. It complements the transmit path and occupies one 16-byte slot on the interconnect. It always answers with zero wait states and OKAY. It raises a level interrupt while data is pending.

## Interface
- `BAUD_DIV`, 434: HCLK cycles per bit (50 MHz / 115200). Legal range 4..65535.
- `FIFO_DEPTH`, 16: receive FIFO entries. Must be a power of two, at least 2.
- `HCLK`  in  1  single clock; all state is on its rising edge.
- `HRESETn`  in  1  reset, asynchronous assert, active-low.
- `HSEL`  in  1  slot select from the interconnect decoder.
- `HADDR`  in  32  address; only `[3:2]` is decoded.
- `HTRANS`  in  2  transfer type; only NONSEQ and SEQ (`HTRANS[1]`=1) are acted on.
- `HSIZE`  in  3  ignored; every access is treated as a word access.
- `HWRITE`  in  1  1 = write.
- `HWDATA`  in  32  write data, sampled in the data phase.
- `HREADY`  in  1  bus-wide ready; qualifies the address phase.
- `HREADYOUT`  out  1  constant 1.
- `HRDATA`  out  32  read data, valid in the data phase.
- `HRESP`  out  1  constant 0 (OKAY).
- `RXD`  in  1  asynchronous serial input; idle level is high.
- `rx_irq`  out  1  registered interrupt request.

## Operation
- **Address phase:** when `HSEL & HREADY & HTRANS[1]`, register `HADDR[3:2]`, `HWRITE` and a valid flag. Otherwise clear the valid flag.
- **Register map:**
  - 0x0 DATA (R): `{24'b0, fifo_head}`. A read pops one entry. A read of an empty FIFO returns 0 and leaves the pointers unchanged.
  - 0x4 STATUS (R): bit0 not_empty, bit1 full, bit2 overrun (sticky), bit3 frame_err (sticky), `[8+:CNT_W]` count, where CNT_W = log2(FIFO_DEPTH)+1.
  - 0x8 CTRL (R/W): bit0 rx_en, bit1 irq_en. Reset value 0x1.
  - 0xC CLEAR (W): writing 1 to bit2 clears overrun; writing 1 to bit3 clears frame_err. Reads return 0.
- Writes to read-only registers are ignored.
- **Input sync:** `RXD` passes through a 2-flop synchronizer; both flops reset to 1. A third flop holds the previous synchronized value for edge detection.
- **Receive FSM:**
  - IDLE: waits for a falling edge of the synchronized input with rx_en=1. Then loads the bit counter with `BAUD_DIV/2 - 1` and goes to START.
  - START: at counter expiry, if the input is still 0, go to DATA with the counter at `BAUD_DIV-1`. Otherwise treat it as a glitch and return to IDLE.
  - DATA: sample once per counter expiry into a shift register, LSB first. After the 8th sample go to STOP.
  - STOP: at counter expiry, a sample of 1 pushes the byte; a sample of 0 sets frame_err and drops the byte. Either way return to IDLE.
  - After a frame error, IDLE needs a fresh falling edge. A held break therefore does not retrigger reception.
- **Push/pop arbitration:**
  - Push while full sets overrun and drops the new byte. The FIFO contents are preserved.
  - Push and pop in the same cycle while full: both occur; no overrun.
  - Push and pop in the same cycle while empty: the pop returns 0 and the push is accepted, leaving count = 1.
- **Sticky flags:** if a set event and a clear write occur in the same cycle, the set wins.
- **Disable:** clearing rx_en forces the FSM to IDLE immediately and discards any partial frame. FIFO contents are kept.
- **Interrupt:** `rx_irq` = registered `(irq_en & not_empty) | (irq_en & overrun)`.

## Timing
- Reset values: `HRDATA`=0, `rx_irq`=0, FSM=IDLE, FIFO empty, sticky flags 0, CTRL=0x1.
- `HRDATA` is combinational from the registered address and current state, valid throughout the data phase.
- A DATA pop takes effect at the end of the data phase. A read of STATUS in the next data phase shows the decremented count.
- The stop-bit sample occurs about 2 + 9.5×BAUD_DIV cycles after the falling edge on the pin. The push is registered at that edge, so not_empty is visible on the next cycle.
- `rx_irq` lags not_empty by one cycle.
- Back-to-back frames with a 1-bit stop are received without loss.
- An asynchronous reset mid-frame or mid-transfer returns every block to its reset values.

## Structure
- A shared package `ahb_uart_pkg` holds:
  - register offset constants (`UART_DATA`=2'd0, `UART_STATUS`, `UART_CTRL`, `UART_CLEAR`);
  - STATUS/CTRL bit-index constants;
  - the RX state enum (IDLE, START, DATA, STOP).
- One sub-module, `sync_fifo`: parameterized width and depth, with push/pop/full/empty/count. It is reused later by the TX side.
- The FSM, synchronizer and bus logic stay in the top-level `ahb_uart_rx`.

## Test plan
All scenarios use `BAUD_DIV`=8 and `FIFO_DEPTH`=4.
- **Single frame:** drive 0xA5 on `RXD`.
  - STATUS reads 0x0000_0101.
  - DATA reads 0xA5.
  - STATUS then reads 0x0.
- **Overrun:** send 5 frames 0x01..0x05 with no reads.
  - STATUS bit1=1, bit2=1, count=4.
  - DATA reads return 0x01..0x04, then 0.
  - Write 0x4 to CLEAR; bit2 reads 0.
- **Frame error:** send a frame with the stop bit low.
  - frame_err=1 and the FIFO stays empty.
  - Hold `RXD` low for 40 cycles; no further activity.
  - A valid 0x3C afterwards is received.
- **Glitch:** a 2-cycle low pulse on `RXD` leaves the FSM in IDLE and pushes nothing.
- **Interrupt and full/pop collision:**
  - With CTRL=0x3, `rx_irq` rises 1 cycle after the push and falls 1 cycle after the DATA read empties the FIFO.
  - With the FIFO full, time a DATA read on the push cycle: no overrun, count stays 4.
- **Disable mid-frame:** clear rx_en during the DATA state; nothing is pushed. After re-enabling, 0x7E is received correctly.

Source files
------------

// File: rtl/ahb_uart_pkg.sv
// Shared definitions for the AHB-Lite UART blocks: register offsets, bit
// positions and the receive state encoding.
package ahb_uart_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_CLEAR  = 2'd3;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_RX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ahb_uart_rx_if.sv
// AHB-Lite slot signals between the interconnect and one UART responder.
interface ahb_uart_rx_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted only
// when a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/ahb_uart_rx.sv
// AHB-Lite UART receiver: 8N1 deserializer feeding a FIFO, with DATA/STATUS/
// CTRL/CLEAR registers and a level interrupt while data or overrun is pending.
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge with rx_en set
//   START | timing to mid start bit, confirming it is still low
//   DATA  | sampling 8 data bits LSB first at mid-bit
//   STOP  | sampling stop bit; push byte or flag frame error
module ahb_uart_rx
  import ahb_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  ahb_uart_rx_if.slave ahb,
  input  logic         RXD,
  output logic         rx_irq
);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] HALF_LOAD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(BAUD_DIV - 1);

  logic [1:0]       addr_q;
  logic             write_q, valid_q;
  logic             rxd_meta, rxd_sync, rxd_prev, rx_fall;
  rx_state_t        state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             push, frame_set, pop, rd_access, wr_access, clear_wr;
  logic [1:0]       ctrl_q;
  logic             overrun_q, frame_err_q, irq_q;
  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      rdata;
  logic             unused_ok;

  assign unused_ok = ^{ahb.HSIZE, ahb.HADDR[31:4], ahb.HADDR[1:0],
                       ahb.HTRANS[0], ahb.HWDATA[31:4]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
      if (ahb.HSEL & ahb.HREADY & ahb.HTRANS[1]) begin
        addr_q  <= ahb.HADDR[3:2];
        write_q <= ahb.HWRITE;
      end
    end
  end

  assign rd_access = valid_q & ~write_q;
  assign wr_access = valid_q & write_q;
  assign pop       = rd_access & (addr_q == UART_DATA);
  assign clear_wr  = wr_access & (addr_q == UART_CLEAR);

  always_comb begin
    rdata = '0;
    if (rd_access) begin
      case (addr_q)
        UART_DATA:   if (!fifo_empty) rdata[7:0] = fifo_rdata;
        UART_STATUS: begin
          rdata[ST_NOT_EMPTY]            = ~fifo_empty;
          rdata[ST_FULL]                 = fifo_full;
          rdata[ST_OVERRUN]              = overrun_q;
          rdata[ST_FRAME_ERR]            = frame_err_q;
          rdata[ST_COUNT_LSB +: CNT_W]   = fifo_count;
        end
        UART_CTRL:   rdata[1:0] = ctrl_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign rx_fall       = rxd_prev & ~rxd_sync;
  assign rx_irq        = irq_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rxd_meta    <= 1'b1;
      rxd_sync    <= 1'b1;
      rxd_prev    <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      ctrl_q      <= 2'b01;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      if (wr_access && addr_q == UART_CTRL) ctrl_q <= ahb.HWDATA[1:0];
      // A set event in the same cycle as a clear write wins.
      overrun_q   <= (push & fifo_full & ~pop) |
                     (overrun_q & ~(clear_wr & ahb.HWDATA[ST_OVERRUN]));
      frame_err_q <= frame_set |
                     (frame_err_q & ~(clear_wr & ahb.HWDATA[ST_FRAME_ERR]));
      irq_q <= ctrl_q[CTRL_IRQ_EN] & (~fifo_empty | overrun_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    push      = 1'b0;
    frame_set = 1'b0;
    if (cnt_q != '0) cnt_d = cnt_q - 16'd1;
    case (state_q)
      IDLE: if (rx_fall) begin
        cnt_d   = HALF_LOAD;
        state_d = START;
      end
      START: if (cnt_q == '0) begin
        if (!rxd_sync) begin
          state_d = DATA;
          cnt_d   = FULL_LOAD;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (cnt_q == '0) begin
        shift_d = {rxd_sync, shift_q[7:1]};
        cnt_d   = FULL_LOAD;
        if (idx_q == 3'd7) state_d = STOP;
        else               idx_d   = idx_q + 3'd1;
      end
      STOP: if (cnt_q == '0) begin
        if (rxd_sync) push      = 1'b1;
        else          frame_set = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!ctrl_q[CTRL_RX_EN]) begin
      state_d   = IDLE;
      push      = 1'b0;
      frame_set = 1'b0;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push),
    .pop   (pop),
    .wdata (shift_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_ahb_uart_rx.sv
// Directed bench for ahb_uart_rx with an 8-cycle bit period and a 4-entry FIFO.
module tb_ahb_uart_rx;
  localparam int BAUD = 8;
  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_CTRL   = 32'h8;
  localparam logic [31:0] A_CLEAR  = 32'hC;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  logic RXD = 1'b1;
  logic rx_irq;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rd;

  ahb_uart_rx_if bus();

  ahb_uart_rx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(4)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (bus.slave),
    .RXD     (RXD),
    .rx_irq  (rx_irq)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.HSEL = 1'b1; bus.HADDR = addr; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0;
    tick(1);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    data = bus.HRDATA;
    tick(1);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.HSEL = 1'b1; bus.HADDR = addr; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
    tick(1);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = data;
    tick(1);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RXD = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      tick(BAUD);
    end
    RXD = stop_bit;
    tick(BAUD);
  endtask

  initial begin
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010;
    bus.HWRITE = 1'b0; bus.HWDATA = '0; bus.HREADY = 1'b1;
    #2 HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hrdata", bus.HRDATA, 32'h0);
    check("rst_irq", {31'b0, rx_irq}, 32'h0);
    check("hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
    check("hresp", {31'b0, bus.HRESP}, 32'h0);
    HRESETn = 1'b1;
    tick(2);
    rd_check("rst_ctrl", A_CTRL, 32'h1);
    rd_check("rst_status", A_STATUS, 32'h0);

    // single frame
    send_byte(8'hA5, 1'b1);
    tick(2);
    rd_check("single_status", A_STATUS, 32'h0000_0101);
    rd_check("single_data", A_DATA, 32'hA5);
    rd_check("single_status2", A_STATUS, 32'h0);

    // overrun: five back-to-back frames into a 4-entry FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    tick(2);
    rd_check("ovr_status", A_STATUS, 32'h0000_0407);
    rd_check("ovr_d1", A_DATA, 32'h01);
    rd_check("ovr_d2", A_DATA, 32'h02);
    rd_check("ovr_d3", A_DATA, 32'h03);
    rd_check("ovr_d4", A_DATA, 32'h04);
    rd_check("ovr_empty_rd", A_DATA, 32'h0);
    rd_check("ovr_sticky", A_STATUS, 32'h4);
    bus_write(A_CLEAR, 32'h4);
    rd_check("ovr_cleared", A_STATUS, 32'h0);
    rd_check("clear_reads0", A_CLEAR, 32'h0);

    // frame error followed by a held break
    send_byte(8'hC3, 1'b0);
    tick(2);
    rd_check("ferr_status", A_STATUS, 32'h8);
    tick(40);
    rd_check("break_quiet", A_STATUS, 32'h8);
    RXD = 1'b1;
    tick(4);
    send_byte(8'h3C, 1'b1);
    tick(2);
    rd_check("after_ferr_status", A_STATUS, 32'h0000_0109);
    rd_check("after_ferr_data", A_DATA, 32'h3C);
    bus_write(A_CLEAR, 32'h8);
    rd_check("ferr_cleared", A_STATUS, 32'h0);

    // glitch
    RXD = 1'b0;
    tick(2);
    RXD = 1'b1;
    tick(20);
    rd_check("glitch_status", A_STATUS, 32'h0);
    send_byte(8'h66, 1'b1);
    tick(2);
    rd_check("post_glitch_data", A_DATA, 32'h66);

    // interrupt timing
    bus_write(A_CTRL, 32'h3);
    rd_check("ctrl_rw", A_CTRL, 32'h3);
    fork
      send_byte(8'h81, 1'b1);
      begin
        tick(79);
        check("irq_before", {31'b0, rx_irq}, 32'h0);
        tick(1);
        check("irq_rise", {31'b0, rx_irq}, 32'h1);
      end
    join
    rd_check("irq_status", A_STATUS, 32'h0000_0101);
    bus_read(A_DATA, rd);
    check("irq_data", rd, 32'h81);
    check("irq_hold", {31'b0, rx_irq}, 32'h1);
    tick(1);
    check("irq_fall", {31'b0, rx_irq}, 32'h0);

    // pop and push in the same cycle while empty
    fork
      send_byte(8'h42, 1'b1);
      begin
        tick(77);
        bus_read(A_DATA, rd);
        check("empty_coll_rd", rd, 32'h0);
      end
    join
    tick(2);
    rd_check("empty_coll_status", A_STATUS, 32'h0000_0101);
    rd_check("empty_coll_data", A_DATA, 32'h42);

    // pop and push in the same cycle while full
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    tick(2);
    rd_check("full_status", A_STATUS, 32'h0000_0403);
    fork
      send_byte(8'h55, 1'b1);
      begin
        tick(77);
        bus_read(A_DATA, rd);
        check("full_coll_rd", rd, 32'h11);
      end
    join
    tick(2);
    rd_check("full_coll_status", A_STATUS, 32'h0000_0403);
    rd_check("full_coll_d2", A_DATA, 32'h22);
    rd_check("full_coll_d3", A_DATA, 32'h33);
    rd_check("full_coll_d4", A_DATA, 32'h44);
    rd_check("full_coll_d5", A_DATA, 32'h55);
    rd_check("full_drained", A_STATUS, 32'h0);

    // disable mid-frame
    fork
      send_byte(8'h99, 1'b1);
      begin
        tick(30);
        bus_write(A_CTRL, 32'h0);
      end
    join
    tick(4);
    rd_check("disable_status", A_STATUS, 32'h0);
    bus_write(A_CTRL, 32'h1);
    send_byte(8'h7E, 1'b1);
    tick(2);
    rd_check("reen_status", A_STATUS, 32'h0000_0101);
    rd_check("reen_data", A_DATA, 32'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
